// File: rtl/palette_lut.sv
// palette_lut: self-initialising colour look-up RAM with a registered read
// path of selectable latency (RD_LAT = 1 or 2) and a one-cycle valid strobe.
module palette_lut #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  input  logic              init_mode,
  output logic              busy,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_add,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {SWEEP, IDLE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt, ra_q;
  logic mode, ra_v;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_mem;
  assign busy = state == SWEEP;
  assign rd_mem = mem[ra_q];
  always_comb begin
    state_nxt = state;
    state_nxt = busy ? (&cnt ? IDLE : SWEEP) : (init_req ? SWEEP : IDLE);
  end
  // The launch stage only registers the address; the RAM is read one edge
  // later, so a same-cycle write lands first and a following write lands after.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SWEEP;
      cnt   <= '0;
      mode  <= 1'b0;
      ra_v  <= 1'b0;
      ra_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= busy ? cnt + ADDR_W'(1) : '0;
      if (!busy && init_req) mode <= init_mode;
      ra_v  <= !busy && rd_req;
      if (!busy && rd_req) ra_q <= rd_add;
    end
  always_ff @(posedge clk)
    if (busy) mem[cnt] <= mode ? '0 : DATA_W'(cnt);
    else if (wr_req) mem[wr_add] <= wr_data;
  generate
    if (RD_LAT == 2) begin : g_lat2
      logic s1_v;
      logic [DATA_W-1:0] s1_d;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          s1_v     <= 1'b0;
          s1_d     <= '0;
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          s1_v     <= ra_v;
          s1_d     <= rd_mem;
          rd_valid <= s1_v;
          if (s1_v) rd_data <= s1_d;
        end
    end else begin : g_lat1
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= ra_v;
          if (ra_v) rd_data <= rd_mem;
        end
    end
  endgenerate
endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: directed + random stimulus for three palette_lut configurations
// checked every cycle against an array/queue reference model.
module tb_palette_lut;
  logic clk = 1'b0, rst_n = 1'b0;
  logic init_req = 1'b0, init_mode = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic [7:0] wr_add = '0, rd_add = '0;
  logic [11:0] wr_data = '0;
  logic rr2 = 1'b0;
  logic [3:0] ra2 = '0;
  logic busy0, busy1, busy2, rv0, rv1, rv2;
  logic [11:0] rd0, rd1;
  logic [2:0] rd2;
  typedef struct {int due; int val;} rd_t;
  rd_t q[3][$];
  int mem[256];
  int held[3];
  int bl, bl2, smode, cyc, checks, errors;

  palette_lut #(.ADDR_W(8), .DATA_W(12), .RD_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_mode(init_mode), .busy(busy0),
    .wr_req(wr_req), .wr_add(wr_add), .wr_data(wr_data), .rd_req(rd_req), .rd_add(rd_add),
    .rd_valid(rv0), .rd_data(rd0));
  palette_lut #(.ADDR_W(8), .DATA_W(12), .RD_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_mode(init_mode), .busy(busy1),
    .wr_req(wr_req), .wr_add(wr_add), .wr_data(wr_data), .rd_req(rd_req), .rd_add(rd_add),
    .rd_valid(rv1), .rd_data(rd1));
  palette_lut #(.ADDR_W(4), .DATA_W(3), .RD_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .init_req(1'b0), .init_mode(1'b0), .busy(busy2),
    .wr_req(1'b0), .wr_add(4'h0), .wr_data(3'h0), .rd_req(rr2), .rd_add(ra2),
    .rd_valid(rv2), .rd_data(rd2));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outs();
    logic [31:0] gv[3], gd[3];
    int ev;
    gv[0] = 32'(rv0); gv[1] = 32'(rv1); gv[2] = 32'(rv2);
    gd[0] = 32'(rd0); gd[1] = 32'(rd1); gd[2] = 32'(rd2);
    for (int i = 0; i < 3; i++) begin
      ev = 0;
      if (q[i].size() > 0 && q[i][0].due == cyc) begin
        rd_t e;
        e = q[i].pop_front();
        ev = 1;
        held[i] = e.val;
      end
      chk($sformatf("rd_valid%0d", i), gv[i], 32'(ev));
      chk($sformatf("rd_data%0d", i), gd[i], 32'(held[i]));
    end
    chk("busy0", 32'(busy0), 32'(bl > 0));
    chk("busy1", 32'(busy1), 32'(bl > 0));
    chk("busy2", 32'(busy2), 32'(bl2 > 0));
  endtask

  task automatic tick();
    int v;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (bl > 0) begin
        bl--;
        if (bl == 0) for (int a = 0; a < 256; a++) mem[a] = smode ? 0 : a;
      end else begin
        if (rd_req) begin
          if (wr_req && wr_add == rd_add) v = int'(wr_data);
          else v = mem[rd_add];
          q[0].push_back('{cyc + 1, v});
          q[1].push_back('{cyc + 2, v});
        end
        if (wr_req) mem[wr_add] = int'(wr_data);
        if (init_req) begin
          bl = 256;
          smode = int'(init_mode);
        end
      end
      if (bl2 > 0) bl2--;
      else if (rr2) q[2].push_back('{cyc + 2, int'(ra2) % 8});
    end
    #1;
    check_outs();
    rr2 = 1'($urandom_range(0, 1));
    ra2 = 4'($urandom_range(0, 15));
  endtask

  task automatic op(int ir, int im, int w, int wa, int wd, int r, int ra);
    init_req = ir[0]; init_mode = im[0];
    wr_req = w[0]; wr_add = 8'(wa); wr_data = 12'(wd);
    rd_req = r[0]; rd_add = 8'(ra);
    tick();
  endtask

  task automatic idle(int n);
    repeat (n) op(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_op(int amax, int allow_init);
    op(allow_init ? int'($urandom_range(0, 1)) : 0, int'($urandom_range(0, 1)),
       int'($urandom_range(0, 1)), int'($urandom_range(0, amax)), int'($urandom_range(0, 4095)),
       int'($urandom_range(0, 1)), int'($urandom_range(0, amax)));
  endtask

  task automatic do_reset();
    init_req = 0; wr_req = 0; rd_req = 0;
    rst_n = 1'b0;
    #1;
    bl = 256; bl2 = 16; smode = 0;
    for (int i = 0; i < 3; i++) begin
      held[i] = 0;
      q[i].delete();
    end
    check_outs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    repeat (256) rand_op(255, 1);
    op(0, 0, 0, 0, 0, 1, 'h00);
    op(0, 0, 0, 0, 0, 1, 'h7F);
    op(0, 0, 0, 0, 0, 1, 'hFF);
    idle(3);
    op(0, 0, 1, 'h10, 'hABC, 0, 0);
    op(0, 0, 0, 0, 0, 1, 'h10);
    idle(2);
    op(0, 0, 0, 0, 0, 1, 'h11);
    idle(3);
    op(0, 0, 1, 'h20, 'h5A5, 1, 'h20);
    idle(3);
    op(0, 0, 0, 0, 0, 1, 'h20);
    op(0, 0, 1, 'h20, 'h111, 0, 0);
    idle(3);
    op(0, 0, 0, 0, 0, 1, 'h20);
    idle(3);
    repeat (300) rand_op(7, 0);
    op(1, 1, 1, 'h30, 'h123, 1, 'h30);
    repeat (256) rand_op(255, 1);
    for (int a = 0; a < 256; a++) op(0, 0, 0, 0, 0, 1, a);
    idle(3);
    op(1, 1, 0, 0, 0, 0, 0);
    repeat (100) rand_op(255, 1);
    do_reset();
    repeat (256) rand_op(255, 1);
    op(0, 0, 0, 0, 0, 1, 'h05);
    do_reset();
    repeat (256) rand_op(255, 1);
    for (int a = 0; a < 256; a++) op(0, 0, 0, 0, 0, 1, a);
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/palette_lut.md
# palette_lut

Parametrised single-clock colour look-up RAM for the pixel path. It sits between the palette-programming interface and the pixel pipeline. It has the following properties:
- Self-initialises after reset and on request: identity ramp or all-zero.
- Registered read with selectable latency and a valid strobe.
- Write-first behaviour when a write and a read hit the same address in the same cycle.
- Replaces the earlier fixed-size dual-clock palette RAM, which had no reset-time contents management and no read handshake.

## Interface
Parameters:
- ADDR_W, 8, address width; DEPTH = 1 << ADDR_W entries
- DATA_W, 12, entry width (RGB444 by default)
- RD_LAT, 1, read latency in cycles; legal values 1 or 2

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- init_req  in  1  one-cycle request to re-run the init sweep
- init_mode  in  1  sweep contents: 0 = identity, 1 = all-zero; sampled with init_req
- busy  out  1  high while a sweep is in progress
- wr_req  in  1  write strobe
- wr_add  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_req  in  1  read strobe
- rd_add  in  ADDR_W  read address
- rd_valid  out  1  one-cycle strobe: rd_data holds a new result
- rd_data  out  DATA_W  read result; held between rd_valid pulses

## Operation
- FSM states: SWEEP, IDLE. Reset state is SWEEP with init_mode = 0 (identity).
- SWEEP:
  - Address counter runs 0..DEPTH-1 and writes one entry per cycle.
  - Identity value = counter zero-extended to DATA_W, or truncated to its low DATA_W bits if DATA_W < ADDR_W.
  - Zero mode writes 0.
  - After writing entry DEPTH-1 the FSM goes to IDLE and the counter returns to 0.
- IDLE:
  - wr_req writes wr_data to mem[wr_add].
  - rd_req launches a read of mem[rd_add].
  - init_req=1 goes to SWEEP, latching init_mode.
- While busy:
  - wr_req, rd_req and init_req are ignored.
  - Ignored requests have no side effects and are not queued.
- Same-cycle wr_req and rd_req in IDLE:
  - Same address: the read returns wr_data (write-first).
  - Different addresses: both complete independently.
- Same-cycle init_req and wr_req/rd_req in IDLE: the write and the read are performed, then the sweep starts next cycle. The sweep overwrites the written entry.
- Reads in flight when a sweep starts complete normally with the data captured at launch.
- RD_LAT=2:
  - Stage 1 captures memory data.
  - Stage 2 is the output register.
  - A write in the cycle after a read launch does not change that read's result.

## Timing
- Reset values (rst_n=0):
  - busy=1, rd_valid=0, rd_data=0.
  - Read pipeline valid bits cleared; FSM=SWEEP, counter=0.
  - Memory contents are not reset; the sweep rewrites them.
- Sweep after reset:
  - The first rising edge after rst_n deasserts writes entry 0.
  - busy stays high for exactly DEPTH rising edges, then falls after the edge that writes entry DEPTH-1.
  - The first accepted request is in the cycle where busy=0.
- init_req sampled high in IDLE at edge N: busy=1 after edge N; entry 0 is written at edge N+1; busy falls after edge N+DEPTH.
- Read latency: rd_req sampled at edge N gives rd_valid=1 and rd_data valid after edge N+RD_LAT, for one cycle.
- Throughput: back-to-back rd_req on consecutive cycles gives consecutive rd_valid pulses. No stalls, no backpressure.
- Write: visible to a read launched in the same cycle (bypass) and to any later read.
- Reset asserted mid-sweep or mid-read:
  - All outputs go immediately to their reset values.
  - In-flight reads are discarded (no rd_valid).
  - The sweep restarts from entry 0 in identity mode.
- Address wrap: the counter stops at DEPTH-1 and does not wrap into a second pass.

## Test plan
- Reset, defaults (ADDR_W=8, DATA_W=12, RD_LAT=1) -> busy high for exactly 256 edges; then reads of addr 0x00, 0x7F, 0xFF return 0x000, 0x07F, 0x0FF, each with rd_valid one cycle after rd_req.
- Write 0xABC to addr 0x10, then read 0x10 -> 0xABC. Read 0x11 -> 0x011. rd_data holds 0xABC/0x011 between valid pulses.
- Same-cycle wr_req and rd_req at addr 0x20 with data 0x5A5 -> rd_data=0x5A5. With RD_LAT=2, a write of 0x111 to 0x20 one cycle after a read launch -> the read still returns the prior value.
- init_req with init_mode=1 in IDLE:
  - busy rises next cycle for 256 cycles.
  - wr_req and rd_req issued during busy produce no rd_valid and no memory change.
  - Afterwards every address reads 0x000.
- rst_n pulsed low at sweep step 100 and during an in-flight read -> rd_valid never pulses for the discarded read; busy stays high for 256 edges after release; the identity contents are restored.
- ADDR_W=4, DATA_W=3, RD_LAT=2 -> busy high for 16 cycles; addr 0xD reads 3'b101 (truncated) two cycles after rd_req.
